// File: rtl/ppwm_spi_loader.sv
`timescale 1ns/1ps
// ppwm_spi_loader
// SPI mode-0 slave. It receives 16-bit program frames (wr, addr, data) and
// presents each write frame on a valid/ready port to the PPWM program store.
// Ports:
//   clk, rst_n              system clock, async active-low reset
//   ena                     block enable; when low the FSM is held in IDLE
//   spi_sck/cs_n/mosi       SPI pins, asynchronous to clk
//   spi_miso, spi_miso_oe   readback data and pad enable
//   prog_valid/ready        write handshake
//   prog_addr, prog_data    write payload, held stable while prog_valid
//   frame_cnt               accepted-write counter (wraps)
//   ovf                     sticky overrun flag (a write frame was dropped)
// Optional feature: define PPWM_SPI_LOADER_READBACK_EN to shift the last
// accepted frame out on MISO during every frame. Without it MISO/OE are tied 0.
module ppwm_spi_loader #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              spi_sck,
  input  logic              spi_cs_n,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic              spi_miso_oe,
  output logic              prog_valid,
  input  logic              prog_ready,
  output logic [ADDR_W-1:0] prog_addr,
  output logic [DATA_W-1:0] prog_data,
  output logic [7:0]        frame_cnt,
  output logic              ovf
);

  localparam int FW = 1 + ADDR_W + DATA_W;
  localparam int CW = $clog2(FW);

  typedef enum logic [0:0] {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  logic sck_meta_r, sck_sync_r, sck_dly_r;
  logic cs_meta_r, cs_sync_r, cs_dly_r;
  logic mosi_meta_r, mosi_sync_r;

  state_t          state_r, state_nxt_s;
  logic [CW-1:0]   bit_cnt_r;
  logic [FW-2:0]   shreg_r;
  logic [FW-1:0]   frame_s;
  logic            sck_rise_s, cs_fall_s, cs_rise_s;
  logic            shift_en_s, frame_done_s, accept_s, load_s, drop_s;

  logic              prog_valid_r;
  logic [ADDR_W-1:0] prog_addr_r;
  logic [DATA_W-1:0] prog_data_r;
  logic [7:0]        frame_cnt_r;
  logic              ovf_r;

  // Two-flop synchronizers plus a delayed copy of SCK/CS for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sck_meta_r  <= 1'b0;
      sck_sync_r  <= 1'b0;
      sck_dly_r   <= 1'b0;
      cs_meta_r   <= 1'b1;
      cs_sync_r   <= 1'b1;
      cs_dly_r    <= 1'b1;
      mosi_meta_r <= 1'b0;
      mosi_sync_r <= 1'b0;
    end else begin
      sck_meta_r  <= spi_sck;
      sck_sync_r  <= sck_meta_r;
      sck_dly_r   <= sck_sync_r;
      cs_meta_r   <= spi_cs_n;
      cs_sync_r   <= cs_meta_r;
      cs_dly_r    <= cs_sync_r;
      mosi_meta_r <= spi_mosi;
      mosi_sync_r <= mosi_meta_r;
    end
  end

  assign sck_rise_s = sck_sync_r & ~sck_dly_r;
  assign cs_fall_s  = ~cs_sync_r & cs_dly_r;
  assign cs_rise_s  = cs_sync_r & ~cs_dly_r;

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next state plus frame-completion and handshake decode
  always_comb begin
    state_nxt_s  = state_r;
    shift_en_s   = 1'b0;
    frame_done_s = 1'b0;
    accept_s     = prog_valid_r & prog_ready;
    load_s       = 1'b0;
    drop_s       = 1'b0;
    frame_s      = {shreg_r, mosi_sync_r};
    case (state_r)
      IDLE: begin
        if (ena && cs_fall_s) begin
          state_nxt_s = SHIFT;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      SHIFT: begin
        if (!ena || cs_rise_s) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = SHIFT;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
    // An SCK edge coinciding with CS rising or ena dropping is ignored
    if (state_r == SHIFT && state_nxt_s == SHIFT && sck_rise_s) begin
      shift_en_s = 1'b1;
    end else begin
      shift_en_s = 1'b0;
    end
    frame_done_s = shift_en_s && (bit_cnt_r == CW'(FW - 1));
    // A frame landing on the handshake edge takes the slot being vacated
    if (frame_done_s && frame_s[FW-1]) begin
      load_s = ~prog_valid_r | accept_s;
      drop_s = prog_valid_r & ~accept_s;
    end else begin
      load_s = 1'b0;
      drop_s = 1'b0;
    end
  end

  // Bit counter and shift register; a partial frame is discarded in IDLE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt_r <= '0;
      shreg_r   <= '0;
    end else if (state_r != SHIFT) begin
      bit_cnt_r <= '0;
    end else if (shift_en_s) begin
      shreg_r <= frame_s[FW-2:0];
      if (frame_done_s) begin
        bit_cnt_r <= '0;
      end else begin
        bit_cnt_r <= bit_cnt_r + CW'(1);
      end
    end
  end

  // Holding register, write handshake, accepted counter and overrun flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prog_valid_r <= 1'b0;
      prog_addr_r  <= '0;
      prog_data_r  <= '0;
      frame_cnt_r  <= 8'd0;
      ovf_r        <= 1'b0;
    end else begin
      if (load_s) begin
        prog_valid_r <= 1'b1;
        prog_addr_r  <= frame_s[FW-2 -: ADDR_W];
        prog_data_r  <= frame_s[DATA_W-1:0];
      end else if (accept_s) begin
        prog_valid_r <= 1'b0;
      end
      if (accept_s) begin
        frame_cnt_r <= frame_cnt_r + 8'd1;
      end
      if (drop_s) begin
        ovf_r <= 1'b1;
      end
    end
  end

  assign prog_valid = prog_valid_r;
  assign prog_addr  = prog_addr_r;
  assign prog_data  = prog_data_r;
  assign frame_cnt  = frame_cnt_r;
  assign ovf        = ovf_r;

`ifdef PPWM_SPI_LOADER_READBACK_EN
  logic          sck_fall_s;
  logic [FW-1:0] rb_r;
  logic [FW-2:0] tx_r;
  logic          miso_r, oe_r;

  assign sck_fall_s = ~sck_sync_r & sck_dly_r;

  // Readback source: last frame loaded onto the write port
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rb_r <= '0;
    end else if (load_s) begin
      rb_r <= frame_s;
    end
  end

  // MISO shifter: MSB on entry to SHIFT, next bit on each SCK fall; after a
  // completed frame (counter back at 0) the next fall restarts from rb_r
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_r   <= '0;
      miso_r <= 1'b0;
      oe_r   <= 1'b0;
    end else begin
      oe_r <= (state_nxt_s == SHIFT);
      if (state_r == IDLE && state_nxt_s == SHIFT) begin
        tx_r   <= rb_r[FW-2:0];
        miso_r <= rb_r[FW-1];
      end else if (state_nxt_s != SHIFT) begin
        miso_r <= 1'b0;
      end else if (sck_fall_s) begin
        if (bit_cnt_r == '0) begin
          tx_r   <= rb_r[FW-2:0];
          miso_r <= rb_r[FW-1];
        end else begin
          tx_r   <= {tx_r[FW-3:0], 1'b0};
          miso_r <= tx_r[FW-2];
        end
      end
    end
  end

  assign spi_miso    = miso_r;
  assign spi_miso_oe = oe_r;
`else
  assign spi_miso    = 1'b0;
  assign spi_miso_oe = 1'b0;
`endif

endmodule

// File: tb/tb_ppwm_spi_loader.sv
`timescale 1ns/1ps
// Scoreboard bench for ppwm_spi_loader: the stimulus pushes expected
// {addr,data} words, the monitor pops one on every handshake.
module tb_ppwm_spi_loader;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       ena = 1'b0;
  logic       spi_sck = 1'b0;
  logic       spi_cs_n = 1'b1;
  logic       spi_mosi = 1'b0;
  logic       prog_ready = 1'b0;
  logic       spi_miso, spi_miso_oe, prog_valid, ovf;
  logic [6:0] prog_addr;
  logic [7:0] prog_data, frame_cnt;

  int          checks = 0;
  int          failures = 0;
  logic [14:0] sb_q[$];
  logic [14:0] mon_exp;
  logic [15:0] rx;
  logic [15:0] v;
  int          oe_hi, oe_lo;

  ppwm_spi_loader dut (
    .clk(clk), .rst_n(rst_n), .ena(ena),
    .spi_sck(spi_sck), .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi),
    .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe),
    .prog_valid(prog_valid), .prog_ready(prog_ready),
    .prog_addr(prog_addr), .prog_data(prog_data),
    .frame_cnt(frame_cnt), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every handshake must match the head of the scoreboard
  always @(negedge clk) begin
    if (rst_n && prog_valid && prog_ready) begin
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write: got 0x%0h expected none", {prog_addr, prog_data});
      end else begin
        mon_exp = sb_q.pop_front();
        check("write", {17'd0, prog_addr, prog_data}, {17'd0, mon_exp});
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    spi_cs_n = 1'b1;
    spi_sck = 1'b0;
    spi_mosi = 1'b0;
    #1;
    check("reset_outputs",
          {5'd0, prog_valid, prog_addr, prog_data, frame_cnt, ovf, spi_miso, spi_miso_oe}, 32'd0);
    tick(3);
    rst_n = 1'b1;
    tick(3);
  endtask

  // Mode-0 master: data set while SCK low, DUT MISO sampled just before each rise
  task automatic spi_frame(input logic [15:0] val, input int nbits, input bit keep_cs);
    spi_cs_n = 1'b0;
    tick(4);
    for (int i = 0; i < nbits; i++) begin
      spi_mosi = val[15-i];
      tick(4);
      rx = {rx[14:0], spi_miso};
      if (spi_miso_oe) oe_hi++; else oe_lo++;
      spi_sck = 1'b1;
      tick(4);
      spi_sck = 1'b0;
    end
    tick(4);
    if (!keep_cs) begin
      spi_cs_n = 1'b1;
      tick(4);
    end
  endtask

  initial begin
    #3;
    do_reset();

    // Single write
    ena = 1'b1;
    prog_ready = 1'b1;
    sb_q.push_back({7'h0A, 8'h5C});
    spi_frame(16'h8A5C, 16, 1'b0);
    tick(6);
    check("single_cnt", {24'd0, frame_cnt}, 32'd1);
    check("single_valid_clear", {31'd0, prog_valid}, 32'd0);
    check("single_ovf", {31'd0, ovf}, 32'd0);

    // Read frame is consumed but not forwarded
    spi_frame(16'h0A5C, 16, 1'b0);
    tick(6);
    check("read_cnt", {24'd0, frame_cnt}, 32'd1);

    // Readback of the last accepted frame during a read frame
    rx = 16'h0000;
    oe_hi = 0;
    oe_lo = 0;
    spi_frame(16'h0000, 16, 1'b0);
    tick(6);
`ifdef PPWM_SPI_LOADER_READBACK_EN
    check("readback_bits", {16'd0, rx}, 32'h8A5C);
    check("readback_oe_low", oe_lo, 32'd0);
`else
    check("miso_tied", {16'd0, rx}, 32'h0000);
    check("oe_tied", oe_hi, 32'd0);
`endif
    check("readback_cnt", {24'd0, frame_cnt}, 32'd1);

    // Back-pressure and overrun
    do_reset();
    ena = 1'b1;
    prog_ready = 1'b0;
    spi_frame(16'h8101, 16, 1'b1);
    spi_frame(16'h8202, 16, 1'b0);
    tick(6);
    check("bp_valid", {31'd0, prog_valid}, 32'd1);
    check("bp_payload", {17'd0, prog_addr, prog_data}, {17'd0, 7'h01, 8'h01});
    check("bp_ovf", {31'd0, ovf}, 32'd1);
    check("bp_cnt_hold", {24'd0, frame_cnt}, 32'd0);
    sb_q.push_back({7'h01, 8'h01});
    prog_ready = 1'b1;
    tick(8);
    check("bp_valid_clear", {31'd0, prog_valid}, 32'd0);
    check("bp_cnt", {24'd0, frame_cnt}, 32'd1);
    check("bp_ovf_sticky", {31'd0, ovf}, 32'd1);

    // CS abort discards a partial frame
    do_reset();
    ena = 1'b1;
    prog_ready = 1'b1;
    spi_frame(16'h8444, 9, 1'b0);
    sb_q.push_back({7'h03, 8'h33});
    spi_frame(16'h8333, 16, 1'b0);
    tick(6);
    check("abort_cnt", {24'd0, frame_cnt}, 32'd1);

    // ena low: SCK ignored
    ena = 1'b0;
    spi_frame(16'h8555, 16, 1'b0);
    tick(6);
    check("ena_low_cnt", {24'd0, frame_cnt}, 32'd1);
    check("ena_low_valid", {31'd0, prog_valid}, 32'd0);

    // 256 back-to-back write frames wrap frame_cnt
    do_reset();
    ena = 1'b1;
    prog_ready = 1'b1;
    for (int i = 0; i < 256; i++) begin
      v = {1'b1, 7'(i), 8'(i)};
      sb_q.push_back(v[14:0]);
      spi_frame(v, 16, 1'b1);
    end
    spi_cs_n = 1'b1;
    tick(8);
    check("wrap_cnt", {24'd0, frame_cnt}, 32'd0);
    check("wrap_sb_drained", sb_q.size(), 32'd0);

    // Reset mid-frame with a write pending
    prog_ready = 1'b0;
    spi_frame(16'h8777, 16, 1'b0);
    tick(6);
    check("pend_valid", {31'd0, prog_valid}, 32'd1);
    spi_frame(16'h8111, 5, 1'b1);
    do_reset();
    prog_ready = 1'b1;
    tick(20);
    check("post_reset_valid", {31'd0, prog_valid}, 32'd0);
    check("post_reset_cnt", {24'd0, frame_cnt}, 32'd0);

    check("sb_empty", sb_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
